msrv32_imm_sequencer: RTL and testbench

Decode-stage front end for the RV32 immediate path. It accepts fetched instructions over a valid/ready handshake, classifies each opcode into the 3-bit immediate-type code consumed by `msrv32_imm_generator`, and holds the instruction in a 2-entry skid buffer. It then presents `{instr[31:7], imm_type}` to the generator and the downstream execute stage. It owns sequencing only (back-pressure, flush, ordering); immediate formation stays in the generator.

---
 rtl/msrv32_imm_sequencer_pkg.sv | 43 ++++
 rtl/msrv32_imm_sequencer_decoder.sv | 42 ++++
 rtl/msrv32_imm_sequencer.sv | 107 ++++++++++
 tb/tb_msrv32_imm_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_imm_sequencer_pkg.sv
// Shared definitions for the RV32 immediate-path front end: opcodes,
// immediate-type codes, buffer states and the buffered entry layout.
package msrv32_imm_sequencer_pkg;

  // Major opcodes, instr[6:0]
  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] MISC_MEM = 7'b0001111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;

  // Immediate-type codes understood by msrv32_imm_generator
  localparam logic [2:0] IMM_R     = 3'b000;
  localparam logic [2:0] IMM_I     = 3'b001;
  localparam logic [2:0] IMM_S     = 3'b010;
  localparam logic [2:0] IMM_B     = 3'b011;
  localparam logic [2:0] IMM_U     = 3'b100;
  localparam logic [2:0] IMM_J     = 3'b101;
  localparam logic [2:0] IMM_CSR   = 3'b110;
  localparam logic [2:0] IMM_I_ALT = 3'b111;

  // Occupancy of the output register plus skid register
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  // One held instruction, already classified
  typedef struct packed {
    logic [31:0] pc;
    logic [24:0] instr;
    logic [2:0]  imm_type;
    logic        illegal;
  } seq_entry_t;

endpackage

// File: rtl/msrv32_imm_sequencer_decoder.sv
// Combinational opcode classifier: instruction word -> immediate-type code
// plus an illegal flag for unknown opcodes or non-32-bit encodings.
module msrv32_imm_type_decoder
  import msrv32_imm_sequencer_pkg::*;
(
  input  logic [31:0] instr_in,
  output logic [2:0]  imm_type_out,
  output logic        illegal_out
);

  // Only the opcode and funct3[2] matter; the rest of the word is ignored
  logic unused_bits;
  assign unused_bits = ^{instr_in[31:15], instr_in[13:7]};

  // Map the opcode to its immediate format; anything unknown falls back to I-type
  always_comb begin
    imm_type_out = IMM_I;
    illegal_out  = 1'b0;
    case (instr_in[6:0])
      OP:       imm_type_out = IMM_R;
      OP_IMM:   imm_type_out = IMM_I;
      LOAD:     imm_type_out = IMM_I;
      JALR:     imm_type_out = IMM_I;
      MISC_MEM: imm_type_out = IMM_I;
      STORE:    imm_type_out = IMM_S;
      BRANCH:   imm_type_out = IMM_B;
      LUI:      imm_type_out = IMM_U;
      AUIPC:    imm_type_out = IMM_U;
      JAL:      imm_type_out = IMM_J;
      SYSTEM:   imm_type_out = instr_in[14] ? IMM_CSR : IMM_I_ALT;
      default: begin
        imm_type_out = IMM_I;
        illegal_out  = 1'b1;
      end
    endcase
    if (instr_in[1:0] != 2'b11) begin
      imm_type_out = IMM_I;
      illegal_out  = 1'b1;
    end
  end

endmodule

// File: rtl/msrv32_imm_sequencer.sv
// Decode-stage front end: classifies fetched instructions and holds them in
// a two-entry skid buffer (output register + skid) in strict FIFO order.
// instr_ready_out is a pure state decode, so no combinational path exists
// from dec_ready_in back to fetch.
module msrv32_imm_sequencer
  import msrv32_imm_sequencer_pkg::*;
(
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        instr_valid_in,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic        instr_ready_out,
  input  logic        flush_in,
  input  logic        dec_ready_in,
  output logic        dec_valid_out,
  output logic [24:0] instr_out,
  output logic [2:0]  imm_type_out,
  output logic [31:0] pc_out,
  output logic        illegal_out
);

  buf_state_e state_q, state_d;
  seq_entry_t head_q, head_d;
  seq_entry_t skid_q, skid_d;
  seq_entry_t new_entry;

  logic [2:0] dec_imm_type;
  logic       dec_illegal;
  logic       in_xfer;
  logic       out_xfer;

  msrv32_imm_type_decoder u_decoder (
    .instr_in     (instr_in),
    .imm_type_out (dec_imm_type),
    .illegal_out  (dec_illegal)
  );

  assign instr_ready_out = (state_q != ST_FULL);
  assign dec_valid_out   = (state_q != ST_EMPTY);
  assign in_xfer         = instr_valid_in & instr_ready_out;
  assign out_xfer        = dec_valid_out & dec_ready_in;

  assign instr_out    = head_q.instr;
  assign imm_type_out = head_q.imm_type;
  assign pc_out       = head_q.pc;
  assign illegal_out  = head_q.illegal;

  // Package the incoming word with its classification
  always_comb begin
    new_entry          = '0;
    new_entry.pc       = pc_in;
    new_entry.instr    = instr_in[31:7];
    new_entry.imm_type = dec_imm_type;
    new_entry.illegal  = dec_illegal;
  end

  // Occupancy FSM and data steering; flush wins over any handshake
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush_in) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            head_d  = new_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            head_d = new_entry;
          end else if (in_xfer) begin
            skid_d  = new_entry;
            state_d = ST_FULL;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            head_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State and data registers; reset clears everything and beats flush
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_msrv32_imm_sequencer.sv
// Self-checking bench for msrv32_imm_sequencer: directed classification
// vectors, stall/flush/reset sequences and a randomised scoreboard run.
module tb_msrv32_imm_sequencer;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_ready;
  logic        flush;
  logic        dec_ready;
  logic        dec_valid;
  logic [24:0] instr_o;
  logic [2:0]  imm_type_o;
  logic [31:0] pc_o;
  logic        illegal_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  exp_type;
    logic        exp_illegal;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [24:0] instr;
    logic [2:0]  imm_type;
    logic        illegal;
  } exp_entry_t;

  vec_t       vecs[15];
  exp_entry_t sb[$];

  msrv32_imm_sequencer dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .instr_valid_in       (instr_valid),
    .instr_in             (instr),
    .pc_in                (pc),
    .instr_ready_out      (instr_ready),
    .flush_in             (flush),
    .dec_ready_in         (dec_ready),
    .dec_valid_out        (dec_valid),
    .instr_out            (instr_o),
    .imm_type_out         (imm_type_o),
    .pc_out               (pc_o),
    .illegal_out          (illegal_o)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference opcode map, written straight from the type table
  function automatic logic [3:0] ref_decode(input logic [31:0] w);
    logic [2:0] t;
    logic       ill;
    t   = 3'b001;
    ill = 1'b0;
    case (w[6:0])
      7'b0110011: t = 3'b000;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: t = 3'b001;
      7'b0100011: t = 3'b010;
      7'b1100011: t = 3'b011;
      7'b0110111, 7'b0010111: t = 3'b100;
      7'b1101111: t = 3'b101;
      7'b1110011: t = w[14] ? 3'b110 : 3'b111;
      default: ill = 1'b1;
    endcase
    if (w[1:0] != 2'b11) begin
      t   = 3'b001;
      ill = 1'b1;
    end
    return {t, ill};
  endfunction

  // Drive one cycle of inputs, then land 1 ns after the rising edge
  task automatic applyStimulus(input logic v, input logic [31:0] w,
                               input logic [31:0] p, input logic fl,
                               input logic rdy);
    instr_valid = v;
    instr       = w;
    pc          = p;
    flush       = fl;
    dec_ready   = rdy;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its expectation
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " dec_valid"}, {31'd0, dec_valid}, 32'd0);
    checkOutput({tag, " instr_out"}, {7'd0, instr_o}, 32'd0);
    checkOutput({tag, " imm_type"}, {29'd0, imm_type_o}, 32'd0);
    checkOutput({tag, " pc_out"}, pc_o, 32'd0);
    checkOutput({tag, " illegal"}, {31'd0, illegal_o}, 32'd0);
    checkOutput({tag, " ready"}, {31'd0, instr_ready}, 32'd1);
  endtask

  // Main test sequence
  initial begin
    logic [31:0] a_w, b_w, c_w;
    logic [3:0]  r;
    logic        v, fl, rdy, m_in, m_out;
    logic [31:0] w, p;
    exp_entry_t  e;

    vecs[0]  = '{32'h123450B7, 3'b100, 1'b0};  // LUI
    vecs[1]  = '{32'h0080006F, 3'b101, 1'b0};  // JAL
    vecs[2]  = '{32'h00112223, 3'b010, 1'b0};  // SW
    vecs[3]  = '{32'h3400D073, 3'b110, 1'b0};  // CSRRWI
    vecs[4]  = '{32'h34001073, 3'b111, 1'b0};  // CSRRW
    vecs[5]  = '{32'h0000007F, 3'b001, 1'b1};  // unknown opcode
    vecs[6]  = '{32'h00000010, 3'b001, 1'b1};  // ADDI with [1:0]=00
    vecs[7]  = '{32'h002081B3, 3'b000, 1'b0};  // ADD
    vecs[8]  = '{32'h00000013, 3'b001, 1'b0};  // ADDI
    vecs[9]  = '{32'h00208463, 3'b011, 1'b0};  // BEQ
    vecs[10] = '{32'h00012083, 3'b001, 1'b0};  // LW
    vecs[11] = '{32'h00000097, 3'b100, 1'b0};  // AUIPC
    vecs[12] = '{32'h000080E7, 3'b001, 1'b0};  // JALR
    vecs[13] = '{32'h0000000F, 3'b001, 1'b0};  // FENCE
    vecs[14] = '{32'h00000073, 3'b111, 1'b0};  // ECALL

    // Reset
    rst = 1'b1;
    applyStimulus(1'b1, 32'h123450B7, 32'h10, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h123450B7, 32'h10, 1'b0, 1'b1);
    rst = 1'b0;
    checkResetOutputs("reset");
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("post-reset ready", {31'd0, instr_ready}, 32'd1);
    checkOutput("post-reset valid", {31'd0, dec_valid}, 32'd0);

    // Back-to-back stream of table vectors with the consumer always ready
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b1, vecs[i].instr, 32'h1000 + 32'(i * 4), 1'b0, 1'b1);
      checkOutput($sformatf("vec%0d valid", i), {31'd0, dec_valid}, 32'd1);
      checkOutput($sformatf("vec%0d imm_type", i), {29'd0, imm_type_o}, {29'd0, vecs[i].exp_type});
      checkOutput($sformatf("vec%0d illegal", i), {31'd0, illegal_o}, {31'd0, vecs[i].exp_illegal});
      checkOutput($sformatf("vec%0d pc", i), pc_o, 32'h1000 + 32'(i * 4));
      checkOutput($sformatf("vec%0d instr", i), {7'd0, instr_o}, {7'd0, vecs[i].instr[31:7]});
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("stream drain valid", {31'd0, dec_valid}, 32'd0);

    // Stall: A and B fill the buffer, C is refused until space opens
    a_w = 32'h123450B7; b_w = 32'h0080006F; c_w = 32'h00112223;
    applyStimulus(1'b1, a_w, 32'h200, 1'b0, 1'b0);
    checkOutput("stall A ready", {31'd0, instr_ready}, 32'd1);
    applyStimulus(1'b1, b_w, 32'h204, 1'b0, 1'b0);
    checkOutput("stall full ready", {31'd0, instr_ready}, 32'd0);
    applyStimulus(1'b1, c_w, 32'h208, 1'b0, 1'b0);
    checkOutput("stall C refused ready", {31'd0, instr_ready}, 32'd0);
    checkOutput("stall head A pc", pc_o, 32'h200);
    checkOutput("stall head A type", {29'd0, imm_type_o}, 32'd4);
    applyStimulus(1'b1, c_w, 32'h208, 1'b0, 1'b1);
    checkOutput("release head B pc", pc_o, 32'h204);
    checkOutput("release head B type", {29'd0, imm_type_o}, 32'd5);
    checkOutput("release ready", {31'd0, instr_ready}, 32'd1);
    applyStimulus(1'b1, c_w, 32'h208, 1'b0, 1'b1);
    checkOutput("release head C pc", pc_o, 32'h208);
    checkOutput("release head C type", {29'd0, imm_type_o}, 32'd2);
    checkOutput("release head C valid", {31'd0, dec_valid}, 32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("release no duplicate", {31'd0, dec_valid}, 32'd0);

    // Flush while FULL with a simultaneous offer
    applyStimulus(1'b1, a_w, 32'h300, 1'b0, 1'b0);
    applyStimulus(1'b1, b_w, 32'h304, 1'b0, 1'b0);
    checkOutput("flush pre full", {31'd0, instr_ready}, 32'd0);
    applyStimulus(1'b1, c_w, 32'h308, 1'b1, 1'b1);
    checkOutput("flush valid", {31'd0, dec_valid}, 32'd0);
    checkOutput("flush ready", {31'd0, instr_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      checkOutput($sformatf("flush idle%0d valid", i), {31'd0, dec_valid}, 32'd0);
    end

    // Flush while EMPTY drops the offered word
    applyStimulus(1'b1, a_w, 32'h400, 1'b1, 1'b1);
    checkOutput("flush empty drop", {31'd0, dec_valid}, 32'd0);

    // Reset while FULL: both entries lost
    applyStimulus(1'b1, a_w, 32'h500, 1'b0, 1'b0);
    applyStimulus(1'b1, b_w, 32'h504, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b1, c_w, 32'h508, 1'b0, 1'b1);
    rst = 1'b0;
    checkResetOutputs("midreset");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      checkOutput($sformatf("midreset idle%0d valid", i), {31'd0, dec_valid}, 32'd0);
    end

    // Random traffic against a queue scoreboard
    sb.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      v   = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 6);
      fl  = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 1) == 0) w = vecs[$urandom_range(0, 14)].instr;
      else                           w = $urandom;
      p = 32'h8000_0000 + 32'(cyc * 4);
      checkOutput("rand ready", {31'd0, instr_ready}, {31'd0, (sb.size() < 2)});
      m_in  = v && (sb.size() < 2);
      m_out = (sb.size() > 0) && rdy;
      applyStimulus(v, w, p, fl, rdy);
      if (fl) begin
        sb.delete();
      end else begin
        if (m_out) void'(sb.pop_front());
        if (m_in) begin
          r = ref_decode(w);
          e.pc = p; e.instr = w[31:7]; e.imm_type = r[3:1]; e.illegal = r[0];
          sb.push_back(e);
        end
      end
      checkOutput("rand valid", {31'd0, dec_valid}, {31'd0, (sb.size() > 0)});
      if (sb.size() > 0) begin
        checkOutput("rand pc", pc_o, sb[0].pc);
        checkOutput("rand instr", {7'd0, instr_o}, {7'd0, sb[0].instr});
        checkOutput("rand imm_type", {29'd0, imm_type_o}, {29'd0, sb[0].imm_type});
        checkOutput("rand illegal", {31'd0, illegal_o}, {31'd0, sb[0].illegal});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
